reg_bus_master: RTL and testbench

- Bus-side controller for a bank of tri-state, chip-selected storage registers that share one data-out bus.
- Accepts single read/write requests over a valid/ready handshake.
- Drives one-hot chip-select, one-hot write-enable and write data into the bank, and samples the shared read bus.
- Returns each result over a valid/ready response channel. Sits between the CPU datapath/peripheral decoder and the register bank.

---
 rtl/reg_bus_master_pkg.sv | 25 ++
 rtl/reg_bus_decoder.sv | 29 ++
 rtl/reg_bus_master.sv | 137 +++++++++++++
 tb/tb_reg_bus_master.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bus_master_pkg.sv
// Shared definitions for the register-bus master: controller state encoding
// and the address-to-one-hot decode helper.
package reg_bus_master_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_WAIT = 2'd2,
        RESP      = 2'd3
    } bus_state_e;

    localparam int unsigned MaxRegs = 64;

    // One-hot select for addr; all zeros when addr is not a valid register.
    function automatic logic [MaxRegs-1:0] onehot_decode(input logic [31:0] addr,
                                                         input int unsigned nr_regs);
        logic [MaxRegs-1:0] hot;
        hot = '0;
        if (addr < nr_regs && addr < MaxRegs) begin
            hot[addr[5:0]] = 1'b1;
        end
        return hot;
    endfunction

endpackage

// File: rtl/reg_bus_decoder.sv
// Combinational address decoder: one-hot chip-select / write-enable for the
// register bank, plus an out-of-range flag for the addressed index.
module reg_bus_decoder
    import reg_bus_master_pkg::*;
#(
    parameter int unsigned NrOfRegs = 8,
    parameter int unsigned AddrBits = 3
) (
    input  logic [AddrBits-1:0] addr,
    input  logic                cs_en,
    input  logic                we_en,
    output logic [NrOfRegs-1:0] cs,
    output logic [NrOfRegs-1:0] we,
    output logic                out_of_range
);

    logic [31:0]        addr_ext;
    logic [MaxRegs-1:0] hot;
    logic               unused_hot;

    assign addr_ext     = 32'(addr);
    assign hot          = onehot_decode(addr_ext, NrOfRegs);
    assign unused_hot   = |hot;
    assign out_of_range = (addr_ext >= NrOfRegs);

    assign cs = cs_en ? hot[NrOfRegs-1:0] : '0;
    assign we = we_en ? hot[NrOfRegs-1:0] : '0;

endmodule

// File: rtl/reg_bus_master.sv
// Bus-side controller for a chip-selected register bank: takes single
// read/write requests, drives cs/we/data, and returns one response each.
module reg_bus_master
    import reg_bus_master_pkg::*;
#(
    parameter int unsigned NrOfBits       = 32,
    parameter int unsigned NrOfRegs       = 8,
    parameter int unsigned AddrBits       = 3,
    parameter int unsigned ReadWaitCycles = 1
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                Tick,
    input  logic                ReqValid,
    output logic                ReqReady,
    input  logic                ReqWrite,
    input  logic [AddrBits-1:0] ReqAddr,
    input  logic [NrOfBits-1:0] ReqWData,
    output logic                RspValid,
    input  logic                RspReady,
    output logic [NrOfBits-1:0] RspRData,
    output logic                RspErr,
    output logic [NrOfRegs-1:0] BusCs,
    output logic [NrOfRegs-1:0] BusWe,
    output logic [NrOfBits-1:0] BusD,
    input  logic [NrOfBits-1:0] BusQ,
    output logic                Busy
);

    bus_state_e          state, state_d;
    logic [3:0]          cnt, cnt_d;
    logic [AddrBits-1:0] addr_q, addr_d;
    logic [NrOfBits-1:0] wdata_q, wdata_d;
    logic [NrOfBits-1:0] rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [AddrBits-1:0] dec_addr;
    logic                cs_en, we_en, addr_oor;

    // The decoder checks the live request address in IDLE and drives the bus
    // from the latched address otherwise, so one instance serves both roles.
    assign dec_addr = (state == IDLE) ? ReqAddr : addr_q;
    assign cs_en    = (state == WRITE) || (state == READ_WAIT);
    assign we_en    = (state == WRITE);

    reg_bus_decoder #(
        .NrOfRegs(NrOfRegs),
        .AddrBits(AddrBits)
    ) u_decoder (
        .addr        (dec_addr),
        .cs_en       (cs_en),
        .we_en       (we_en),
        .cs          (BusCs),
        .we          (BusWe),
        .out_of_range(addr_oor)
    );

    // Bus strobes decode straight from state, so reset drops them asynchronously.
    assign BusD     = (state == WRITE) ? wdata_q : '0;
    assign ReqReady = (state == IDLE);
    assign RspValid = (state == RESP);
    assign Busy     = (state != IDLE);
    assign RspRData = rdata_q;
    assign RspErr   = err_q;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state)
            IDLE: begin
                if (ReqValid) begin
                    addr_d  = ReqAddr;
                    wdata_d = ReqWData;
                    rdata_d = '0;
                    if (addr_oor) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (ReqWrite) begin
                        err_d   = 1'b0;
                        state_d = WRITE;
                    end else begin
                        err_d   = 1'b0;
                        cnt_d   = 4'(ReadWaitCycles);
                        state_d = READ_WAIT;
                    end
                end
            end
            WRITE: begin
                if (Tick) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = RESP;
                end
            end
            READ_WAIT: begin
                cnt_d = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    cnt_d   = '0;
                    rdata_d = BusQ;
                    err_d   = 1'b0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (RspReady) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed self-checking bench for reg_bus_master driving a small behavioural
// register bank (6 registers, two-clock read wait).
module tb_reg_bus_master;

    localparam int unsigned NB = 32;
    localparam int unsigned NR = 6;
    localparam int unsigned AB = 3;
    localparam int unsigned RW = 2;

    logic          Clock = 1'b0;
    logic          Reset_n;
    logic          Tick;
    logic          ReqValid;
    logic          ReqReady;
    logic          ReqWrite;
    logic [AB-1:0] ReqAddr;
    logic [NB-1:0] ReqWData;
    logic          RspValid;
    logic          RspReady;
    logic [NB-1:0] RspRData;
    logic          RspErr;
    logic [NR-1:0] BusCs;
    logic [NR-1:0] BusWe;
    logic [NB-1:0] BusD;
    logic [NB-1:0] BusQ;
    logic          Busy;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned viol    = 0;

    logic [NB-1:0] bank [NR];

    reg_bus_master #(
        .NrOfBits(NB),
        .NrOfRegs(NR),
        .AddrBits(AB),
        .ReadWaitCycles(RW)
    ) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .Tick    (Tick),
        .ReqValid(ReqValid),
        .ReqReady(ReqReady),
        .ReqWrite(ReqWrite),
        .ReqAddr (ReqAddr),
        .ReqWData(ReqWData),
        .RspValid(RspValid),
        .RspReady(RspReady),
        .RspRData(RspRData),
        .RspErr  (RspErr),
        .BusCs   (BusCs),
        .BusWe   (BusWe),
        .BusD    (BusD),
        .BusQ    (BusQ),
        .Busy    (Busy)
    );

    always #5 Clock = ~Clock;

    // Behavioural bank: Tick-qualified capture, chip-selected shared read bus.
    always @(posedge Clock) begin
        if (Tick) begin
            for (int i = 0; i < int'(NR); i++) begin
                if (BusWe[i]) bank[i] <= BusD;
            end
        end
    end

    always_comb begin
        BusQ = '0;
        for (int i = 0; i < int'(NR); i++) begin
            if (BusCs[i]) BusQ = BusQ | bank[i];
        end
    end

    always @(negedge Clock) begin
        if (Reset_n && (($countones(BusCs) > 1) || ((BusWe & ~BusCs) != '0))) viol++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_req(input logic wr, input logic [AB-1:0] a, input logic [NB-1:0] d);
        ReqValid = 1'b1;
        ReqWrite = wr;
        ReqAddr  = a;
        ReqWData = d;
        step();
        ReqValid = 1'b0;
    endtask

    task automatic finish_rsp();
        RspReady = 1'b1;
        step();
        RspReady = 1'b0;
    endtask

    initial begin
        Reset_n  = 1'b0;
        Tick     = 1'b0;
        ReqValid = 1'b0;
        ReqWrite = 1'b0;
        ReqAddr  = '0;
        ReqWData = '0;
        RspReady = 1'b0;
        step();
        step();
        check("rst_req_ready", 32'(ReqReady), 32'd1);
        check("rst_rsp_valid", 32'(RspValid), 32'd0);
        check("rst_cs",        32'(BusCs),    32'h0);
        check("rst_we",        32'(BusWe),    32'h0);
        check("rst_d",         BusD,          32'h0);
        check("rst_busy",      32'(Busy),     32'd0);
        check("rst_rdata",     RspRData,      32'h0);
        check("rst_err",       32'(RspErr),   32'd0);
        Reset_n = 1'b1;
        step();

        // Write addr 5 with Tick held low for three edges.
        do_req(1'b1, 3'd5, 32'hDEADBEEF);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) Tick = 1'b1;
            check("wr_cs",   32'(BusCs),    32'h20);
            check("wr_we",   32'(BusWe),    32'h20);
            check("wr_d",    BusD,          32'hDEADBEEF);
            check("wr_busy", 32'(Busy),     32'd1);
            check("wr_wait", 32'(RspValid), 32'd0);
            step();
        end
        Tick = 1'b0;
        check("wr_rsp_valid", 32'(RspValid), 32'd1);
        check("wr_rsp_err",   32'(RspErr),   32'd0);
        check("wr_rsp_data",  RspRData,      32'h0);
        check("wr_rsp_cs",    32'(BusCs),    32'h0);
        check("wr_bank5",     bank[5],       32'hDEADBEEF);
        finish_rsp();
        check("wr_done_valid", 32'(RspValid), 32'd0);

        // Preload register 2, then read it back through the two-clock wait.
        Tick = 1'b1;
        do_req(1'b1, 3'd2, 32'h0000_1234);
        step();
        Tick = 1'b0;
        finish_rsp();
        check("bank2", bank[2], 32'h0000_1234);
        do_req(1'b0, 3'd2, '0);
        check("rd_cs0",   32'(BusCs),    32'h04);
        check("rd_we0",   32'(BusWe),    32'h0);
        check("rd_d0",    BusD,          32'h0);
        check("rd_wait0", 32'(RspValid), 32'd0);
        step();
        check("rd_cs1",   32'(BusCs),    32'h04);
        check("rd_wait1", 32'(RspValid), 32'd0);
        step();
        check("rd_cs2",    32'(BusCs),    32'h0);
        check("rd_valid",  32'(RspValid), 32'd1);
        check("rd_data",   RspRData,      32'h0000_1234);
        check("rd_err",    32'(RspErr),   32'd0);
        finish_rsp();

        // Out-of-range addresses 7 and 6 (first invalid index).
        do_req(1'b0, 3'd7, '0);
        check("oor7_cs",    32'(BusCs),    32'h0);
        check("oor7_valid", 32'(RspValid), 32'd1);
        check("oor7_err",   32'(RspErr),   32'd1);
        check("oor7_data",  RspRData,      32'h0);
        finish_rsp();
        check("oor7_err_clr", 32'(RspErr), 32'd0);
        do_req(1'b1, 3'd6, 32'hFFFF_FFFF);
        check("oor6_cs",  32'(BusCs),  32'h0);
        check("oor6_we",  32'(BusWe),  32'h0);
        check("oor6_err", 32'(RspErr), 32'd1);
        finish_rsp();

        // Back-pressure: a write request waits while the read response stalls.
        do_req(1'b0, 3'd2, '0);
        ReqValid = 1'b1;
        ReqWrite = 1'b1;
        ReqAddr  = 3'd1;
        ReqWData = 32'hA5A5A5A5;
        check("bp_rd_cs0", 32'(BusCs), 32'h04);
        step();
        check("bp_rd_cs1", 32'(BusCs), 32'h04);
        step();
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", 32'(RspValid), 32'd1);
            check("bp_data",  RspRData,      32'h0000_1234);
            check("bp_ready", 32'(ReqReady), 32'd0);
            check("bp_cs",    32'(BusCs),    32'h0);
            step();
        end
        finish_rsp();
        check("bp_idle_ready", 32'(ReqReady), 32'd1);
        check("bp_idle_cs",    32'(BusCs),    32'h0);
        check("bp_idle_valid", 32'(RspValid), 32'd0);
        Tick = 1'b1;
        step();
        ReqValid = 1'b0;
        check("bp_wr_cs", 32'(BusCs), 32'h02);
        check("bp_wr_we", 32'(BusWe), 32'h02);
        check("bp_wr_d",  BusD,       32'hA5A5A5A5);
        step();
        Tick = 1'b0;
        check("bp_wr_valid", 32'(RspValid), 32'd1);
        check("bp_wr_err",   32'(RspErr),   32'd0);
        finish_rsp();

        // Read back the value just written.
        do_req(1'b0, 3'd1, '0);
        check("b2b_cs", 32'(BusCs), 32'h02);
        step();
        step();
        check("b2b_valid", 32'(RspValid), 32'd1);
        check("b2b_data",  RspRData,      32'hA5A5A5A5);
        finish_rsp();

        // Reset asserted in the middle of a stalled write.
        do_req(1'b1, 3'd2, 32'hFFFF_0000);
        check("mid_cs",   32'(BusCs), 32'h04);
        check("mid_busy", 32'(Busy),  32'd1);
        #2;
        Reset_n = 1'b0;
        #1;
        check("async_cs",   32'(BusCs), 32'h0);
        check("async_we",   32'(BusWe), 32'h0);
        check("async_d",    BusD,       32'h0);
        check("async_busy", 32'(Busy),  32'd0);
        step();
        Reset_n = 1'b1;
        step();
        check("post_ready", 32'(ReqReady), 32'd1);
        check("post_valid", 32'(RspValid), 32'd0);
        check("post_bank2", bank[2],       32'h0000_1234);

        check("cs_onehot", viol, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
